// File: rtl/jump_controller_if.sv
// Signal bundle between the jump controller and the display/physics block.
// The controller takes the master modport; the display side (or a bench) takes slave.
interface jump_controller_if;
    logic [31:0] Div;
    logic        btn;
    logic        score_signal;
    logic [3:0]  get_score;
    logic        end_game;
    logic [1:0]  position;
    logic [3:0]  press_time;
    logic        is_pressing;
    logic [7:0]  score;
    logic        game_over;
    logic [2:0]  state;

    modport master (
        input  Div, btn, score_signal, get_score, end_game,
        output position, press_time, is_pressing, score, game_over, state
    );

    modport slave (
        output Div, btn, score_signal, get_score, end_game,
        input  position, press_time, is_pressing, score, game_over, state
    );
endinterface

// File: rtl/jump_controller.sv
// Jump-game controller: debounces and times the jump button, sequences each jump
// through charge/flight/settle, and keeps the saturating score and game-over flag.
module jump_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_BIT        = 21,
    parameter int TIMEOUT_TICKS   = 32
) (
    input logic               clk,
    input logic               rst,
    jump_controller_if.master bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FL_W  = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        FLIGHT = 3'd2,
        SETTLE = 3'd3,
        OVER   = 3'd4
    } state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_db, btn_db_q;
    logic             div_q, ss_q;
    logic             tick, land, press_ev, rel_ev;

    state_t           state_q, state_n;
    logic [1:0]       position_q, position_n;
    logic [3:0]       press_time_q, press_time_n;
    logic             is_pressing_q, is_pressing_n;
    logic [7:0]       score_q, score_n;
    logic             game_over_q, game_over_n;
    logic [FL_W-1:0]  flight_q, flight_n;

    // Only Div[TICK_BIT] and Div[1:0] matter; the rest of the count is deliberately ignored.
    logic unused_div;
    assign unused_div = ^bus.Div;

    // Synchroniser, debounce and edge-history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            div_q    <= bus.Div[TICK_BIT];
            ss_q     <= bus.score_signal;
        end else begin
            sync_q   <= {sync_q[0], bus.btn};
            btn_db_q <= btn_db;
            div_q    <= bus.Div[TICK_BIT];
            ss_q     <= bus.score_signal;
            if (sync_q[1] == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= sync_q[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign tick     = bus.Div[TICK_BIT] & ~div_q;
    assign land     = bus.score_signal ^ ss_q;
    assign press_ev = btn_db & ~btn_db_q;
    assign rel_ev   = ~btn_db & btn_db_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            position_q    <= 2'b00;
            press_time_q  <= 4'd0;
            is_pressing_q <= 1'b0;
            score_q       <= 8'd0;
            game_over_q   <= 1'b0;
            flight_q      <= '0;
        end else begin
            state_q       <= state_n;
            position_q    <= position_n;
            press_time_q  <= press_time_n;
            is_pressing_q <= is_pressing_n;
            score_q       <= score_n;
            game_over_q   <= game_over_n;
            flight_q      <= flight_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        position_n    = position_q;
        press_time_n  = press_time_q;
        is_pressing_n = is_pressing_q;
        score_n       = score_q;
        game_over_n   = game_over_q;
        flight_n      = flight_q;
        // end_game outranks every other event, including a landing in the same cycle.
        if (bus.end_game && state_q != OVER) begin
            state_n       = OVER;
            game_over_n   = 1'b1;
            is_pressing_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_ev) begin
                        state_n       = CHARGE;
                        is_pressing_n = 1'b1;
                        press_time_n  = 4'd0;
                    end
                end
                CHARGE: begin
                    if (tick) press_time_n = sat_inc4(press_time_q);
                    if (rel_ev) begin
                        state_n       = FLIGHT;
                        is_pressing_n = 1'b0;
                        flight_n      = '0;
                    end
                end
                FLIGHT: begin
                    if (tick) flight_n = flight_q + FL_W'(1);
                    if (land) begin
                        score_n = sat_add8(score_q, bus.get_score);
                        state_n = SETTLE;
                    end else if (flight_q >= FL_W'(TIMEOUT_TICKS)) begin
                        state_n = SETTLE;
                    end
                end
                SETTLE: begin
                    position_n   = bus.Div[1:0];
                    press_time_n = 4'd0;
                    state_n      = IDLE;
                end
                OVER: begin
                    game_over_n   = 1'b1;
                    is_pressing_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.position    = position_q;
    assign bus.press_time  = press_time_q;
    assign bus.is_pressing = is_pressing_q;
    assign bus.score       = score_q;
    assign bus.game_over   = game_over_q;
    assign bus.state       = state_q;
endmodule
